// File: rtl/cdr_pkg.sv
// cdr_pkg: shared types and defaults for the CDR word aligner slice.
// Holds the aligner FSM state enum and default word/sync constants.
package cdr_pkg;

  localparam int         DEF_WORD_WIDTH = 8;
  localparam logic [7:0] DEF_SYNC       = 8'hC5;

  typedef enum logic [1:0] {
    IDLE,
    HUNT,
    VERIFY,
    ALIGNED
  } aligner_state_t;

endpackage

// File: rtl/cdr_sipo.sv
// cdr_sipo: serial-in shift register with bit and frame-word counters.
// Ports: clk, rst (sync, high), data_in (serial bit), load (restart
// counters after a sync match; the matched word counts as word 0),
// nxt (shift contents including this edge's bit), boundary (this edge
// completes a word), word_idx (frame position of the word completing).
module cdr_sipo
  import cdr_pkg::*;
#(
  parameter int W  = DEF_WORD_WIDTH,
  parameter int FW = 4,
  parameter int IW = $clog2(FW)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          data_in,
  input  logic          load,
  output logic [W-1:0]  nxt,
  output logic          boundary,
  output logic [IW-1:0] word_idx
);

  localparam int BW = $clog2(W);

  logic [W-2:0]  sr;
  logic [BW-1:0] bit_cnt;

  assign nxt      = {sr, data_in};
  assign boundary = (bit_cnt == BW'(W - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      sr       <= '0;
      bit_cnt  <= '0;
      word_idx <= '0;
    end else begin
      sr <= nxt[W-2:0];
      if (load) begin
        bit_cnt  <= '0;
        word_idx <= IW'(1);
      end else if (boundary) begin
        bit_cnt  <= '0;
        word_idx <= (word_idx == IW'(FW - 1))
                    ? '0 : word_idx + IW'(1);
      end else begin
        bit_cnt <= bit_cnt + BW'(1);
      end
    end
  end

endmodule

// File: rtl/cdr_word_aligner.sv
// cdr_word_aligner: hunts for a sync word in the recovered serial stream,
// verifies it over several frames, then emits aligned parallel words.
// Ports: clk (recovered clock), rst (sync, high), lock (CDR locked),
// data_in (serial bit), word_out/word_valid (aligned word + strobe),
// sync_flag (word is frame position 0), aligned (in ALIGNED state),
// err_cnt (saturating count of missed syncs while aligned).
module cdr_word_aligner
  import cdr_pkg::*;
#(
  parameter int                    WORD_WIDTH   = DEF_WORD_WIDTH,
  parameter logic [WORD_WIDTH-1:0] SYNC_PATTERN = WORD_WIDTH'(DEF_SYNC),
  parameter int                    FRAME_WORDS  = 4,
  parameter int                    VERIFY_COUNT = 3,
  parameter int                    LOSS_COUNT   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  lock,
  input  logic                  data_in,
  output logic [WORD_WIDTH-1:0] word_out,
  output logic                  word_valid,
  output logic                  sync_flag,
  output logic                  aligned,
  output logic [7:0]            err_cnt
);

  localparam int IW = $clog2(FRAME_WORDS);
  localparam int VW = $clog2(VERIFY_COUNT + 1);
  localparam int LW = $clog2(LOSS_COUNT + 1);

  aligner_state_t        state;
  logic [WORD_WIDTH-1:0] nxt;
  logic                  boundary;
  logic [IW-1:0]         word_idx;
  logic [VW-1:0]         verify_cnt;
  logic [LW-1:0]         miss_cnt;
  logic                  match;
  logic                  sync_pos;
  logic                  load;

  assign match    = (nxt == SYNC_PATTERN);
  assign sync_pos = boundary && (word_idx == '0);
  // Loss of lock outranks a hunt match, so no reload then.
  assign load     = lock && (state == HUNT) && match;

  cdr_sipo #(
    .W  (WORD_WIDTH),
    .FW (FRAME_WORDS),
    .IW (IW)
  ) u_sipo (
    .clk      (clk),
    .rst      (rst),
    .data_in  (data_in),
    .load     (load),
    .nxt      (nxt),
    .boundary (boundary),
    .word_idx (word_idx)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      verify_cnt <= '0;
      miss_cnt   <= '0;
      word_out   <= '0;
      word_valid <= 1'b0;
      sync_flag  <= 1'b0;
      aligned    <= 1'b0;
      err_cnt    <= '0;
    end else begin
      word_valid <= 1'b0;
      sync_flag  <= 1'b0;
      if (!lock) begin
        state   <= IDLE;
        aligned <= 1'b0;
      end else begin
        unique case (state)
          IDLE: state <= HUNT;
          HUNT: begin
            if (match) begin
              verify_cnt <= '0;
              state      <= VERIFY;
            end
          end
          VERIFY: begin
            if (sync_pos) begin
              if (match) begin
                verify_cnt <= verify_cnt + VW'(1);
                if (verify_cnt == VW'(VERIFY_COUNT - 1)) begin
                  miss_cnt <= '0;
                  aligned  <= 1'b1;
                  state    <= ALIGNED;
                end
              end else begin
                state <= HUNT;
              end
            end
          end
          ALIGNED: begin
            if (boundary) begin
              word_out   <= nxt;
              word_valid <= 1'b1;
              sync_flag  <= sync_pos;
            end
            if (sync_pos) begin
              if (match) begin
                miss_cnt <= '0;
              end else begin
                miss_cnt <= miss_cnt + LW'(1);
                if (err_cnt != 8'hFF)
                  err_cnt <= err_cnt + 8'd1;
                if (miss_cnt == LW'(LOSS_COUNT - 1)) begin
                  aligned <= 1'b0;
                  state   <= HUNT;
                end
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cdr_word_aligner.sv
// tb_cdr_word_aligner: scoreboard bench for cdr_word_aligner.
// Frames C5,12,34,56 serialised MSB first; expected words queued per edge.
module tb_cdr_word_aligner;
  import cdr_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       lock;
  logic       data_in;
  logic [7:0] word_out;
  logic       word_valid;
  logic       sync_flag;
  logic       aligned;
  logic [7:0] err_cnt;

  cdr_word_aligner dut (
    .clk        (clk),
    .rst        (rst),
    .lock       (lock),
    .data_in    (data_in),
    .word_out   (word_out),
    .word_valid (word_valid),
    .sync_flag  (sync_flag),
    .aligned    (aligned),
    .err_cnt    (err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] w;
    logic       s;
    int         due;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;
  int   last_edge = 0;
  int   rise_cyc = -1;
  logic al_q = 1'b0;
  int   m;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                  tag, got, exp, cyc);
  endtask

  always @(negedge clk) begin : mon
    bit ev;
    ev = (q.size() > 0) && (q[0].due == cyc);
    chk("valid", 32'(word_valid), 32'(ev));
    if (ev) begin
      chk("word", 32'(word_out), 32'(q[0].w));
      chk("sync_flag", 32'(sync_flag), 32'(q[0].s));
      void'(q.pop_front());
    end
    if (aligned === 1'b1 && al_q !== 1'b1) rise_cyc = cyc;
    al_q = aligned;
  end

  task automatic send_word(input logic [7:0] w,
                           input bit push,
                           input bit s);
    for (int i = 7; i >= 0; i--) begin
      @(negedge clk);
      data_in = w[i];
    end
    last_edge = cyc + 1;
    if (push) q.push_back('{w: w, s: s, due: cyc + 1});
  endtask

  task automatic send_zeros(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      data_in = 1'b0;
    end
  endtask

  task automatic send_frame(input logic [7:0] s0,
                            input bit p0,
                            input bit pr);
    send_word(s0, p0, 1'b1);
    send_word(8'h12, pr, 1'b0);
    send_word(8'h34, pr, 1'b0);
    send_word(8'h56, pr, 1'b0);
  endtask

  // First C5 matches in HUNT, three more syncs verify; words
  // are expected from the word after the third verified sync.
  task automatic align_frames(output int match_edge);
    send_word(8'hC5, 1'b0, 1'b1);
    match_edge = last_edge;
    send_word(8'h12, 1'b0, 1'b0);
    send_word(8'h34, 1'b0, 1'b0);
    send_word(8'h56, 1'b0, 1'b0);
    send_frame(8'hC5, 1'b0, 1'b0);
    send_frame(8'hC5, 1'b0, 1'b0);
    send_frame(8'hC5, 1'b0, 1'b1);
    send_frame(8'hC5, 1'b1, 1'b1);
  endtask

  task automatic send_word_drop(input logic [7:0] w);
    for (int i = 7; i >= 0; i--) begin
      @(negedge clk);
      if (i == 3) lock = 1'b0;
      if (i == 2) begin
        chk("drop_state", 32'(int'(dut.state)), 32'(int'(IDLE)));
        chk("drop_aligned", 32'(aligned), 32'd0);
        lock = 1'b1;
      end
      data_in = w[i];
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_word"}, 32'(word_out), 32'd0);
    chk({tag, "_valid"}, 32'(word_valid), 32'd0);
    chk({tag, "_sync"}, 32'(sync_flag), 32'd0);
    chk({tag, "_aligned"}, 32'(aligned), 32'd0);
    chk({tag, "_err"}, 32'(err_cnt), 32'd0);
  endtask

  initial begin
    rst     = 1'b1;
    lock    = 1'b0;
    data_in = 1'b0;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;

    // No lock: stream ignored.
    repeat (7) send_frame(8'hC5, 1'b0, 1'b0);
    chk("s1_aligned", 32'(aligned), 32'd0);
    chk("s1_state", 32'(int'(dut.state)), 32'(int'(IDLE)));

    // Lock, 3-bit offset, acquire.
    lock = 1'b1;
    send_zeros(11);
    align_frames(m);
    chk("s2_latency", 32'(rise_cyc - m), 32'd96);
    chk("s2_aligned", 32'(aligned), 32'd1);
    chk("s2_err", 32'(err_cnt), 32'd0);

    // Three missed syncs: stay aligned.
    repeat (3) send_frame(8'h00, 1'b1, 1'b1);
    send_frame(8'hC5, 1'b1, 1'b1);
    chk("s4a_aligned", 32'(aligned), 32'd1);
    chk("s4a_err", 32'(err_cnt), 32'd3);

    // Four missed syncs: alignment lost on the fourth.
    repeat (3) send_frame(8'h00, 1'b1, 1'b1);
    send_word(8'h00, 1'b1, 1'b1);
    send_word(8'h12, 1'b0, 1'b0);
    chk("s4b_aligned", 32'(aligned), 32'd0);
    chk("s4b_err", 32'(err_cnt), 32'd7);
    chk("s4b_state", 32'(int'(dut.state)), 32'(int'(HUNT)));

    // False sync: C5 at frame position 2.
    send_word(8'hC5, 1'b0, 1'b0);
    send_word(8'h56, 1'b0, 1'b0);
    chk("s3_verify", 32'(int'(dut.state)), 32'(int'(VERIFY)));
    send_frame(8'hC5, 1'b0, 1'b0);
    chk("s3_rehunt", 32'(int'(dut.state)), 32'(int'(HUNT)));
    align_frames(m);
    chk("s3_latency", 32'(rise_cyc - m), 32'd96);
    chk("s3_aligned", 32'(aligned), 32'd1);
    chk("s3_err", 32'(err_cnt), 32'd7);

    // One-cycle lock drop mid-word.
    send_word(8'hC5, 1'b1, 1'b1);
    send_word_drop(8'h12);
    send_word(8'h34, 1'b0, 1'b0);
    send_word(8'h56, 1'b0, 1'b0);
    chk("s5_state", 32'(int'(dut.state)), 32'(int'(HUNT)));
    align_frames(m);
    chk("s5_latency", 32'(rise_cyc - m), 32'd96);
    chk("s5_aligned", 32'(aligned), 32'd1);
    chk("s5_err", 32'(err_cnt), 32'd7);

    // Reset while aligned, then reacquire.
    @(negedge clk);
    rst     = 1'b1;
    data_in = 1'b0;
    @(negedge clk);
    chk_zero("s6_rst");
    chk("s6_state", 32'(int'(dut.state)), 32'(int'(IDLE)));
    rst = 1'b0;
    send_zeros(11);
    align_frames(m);
    chk("s6_latency", 32'(rise_cyc - m), 32'd96);
    chk("s6_aligned", 32'(aligned), 32'd1);
    chk("s6_err", 32'(err_cnt), 32'd0);

    @(negedge clk);
    @(negedge clk);
    chk("queue_empty", 32'(q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
